// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8-bit UART transmitter (start, LSB-first data, STOP_BITS stop bits).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int STOP_BITS    = 1
) (
    input  logic       iCE_CLK,
    input  logic       iCE_RST_N,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       TX,
    output logic       tx_busy,
    output logic       tx_done
);

    // 17 bits covers the longest stop period (2 * 65535 cycles).
    localparam int                CNT_W     = 17;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             r_armed;
`ifdef UART_TX_PARITY_EN
    logic             r_parity;
    logic             w_parity_nxt;
`endif

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_dec;
    logic [2:0]       w_idx_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_tx_nxt;
    logic             w_bit_end;

    // r_armed holds tx_ready low through reset and releases it on the first edge after.
    assign tx_ready  = r_armed && (r_state == IDLE);
    assign tx_busy   = ~tx_ready;
    assign tx_done   = (r_state == STOP) && w_bit_end;
    assign TX        = r_tx;
    assign w_bit_end = (r_cnt == '0);
    assign w_cnt_dec = r_cnt - CNT_W'(1);

    // NOTE: the async reset covers every register here, including the shift register, so
    // the line is forced idle-high the instant reset asserts, not at the next edge.
    always_ff @(posedge iCE_CLK or negedge iCE_RST_N) begin
        if (!iCE_RST_N) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
            r_armed  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_shift  <= w_shift_nxt;
            r_tx     <= w_tx_nxt;
            r_armed  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity <= w_parity_nxt;
`endif
        end
    end

    always_comb begin
        // NOTE: every next value defaults to its current value so no branch infers a latch.
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_shift_nxt  = r_shift;
        w_tx_nxt     = r_tx;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        unique case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (tx_valid && tx_ready) begin
                    w_state_nxt  = START;
                    w_shift_nxt  = tx_byte;
                    w_idx_nxt    = '0;
                    w_cnt_nxt    = BIT_LAST;
                    w_tx_nxt     = 1'b0;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt = ^tx_byte;
`endif
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_cnt_nxt   = BIT_LAST;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            DATA: begin
                if (!w_bit_end) begin
                    w_cnt_nxt = w_cnt_dec;
                end else if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = PARITY;
                    w_cnt_nxt   = BIT_LAST;
                    w_tx_nxt    = r_parity;
`else
                    w_state_nxt = STOP;
                    w_cnt_nxt   = STOP_LAST;
                    w_tx_nxt    = 1'b1;
`endif
                end else begin
                    // r_shift[0] is the bit on the line; r_shift[1] goes out next.
                    w_idx_nxt   = r_idx + 3'd1;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_tx_nxt    = r_shift[1];
                    w_cnt_nxt   = BIT_LAST;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                    w_cnt_nxt   = STOP_LAST;
                    w_tx_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
`endif
            STOP: begin
                w_tx_nxt = 1'b1;
                if (w_bit_end) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: unit A (4 clk/bit, 1 stop) and unit B (4 clk/bit, 2 stop bits).
// Per-cycle TX waveforms are compared against frames built from the framing rules.
`timescale 1ns/1ps
module tb_uart_byte_tx;

    localparam int CLKS = 4;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int PAR = PAR_EN ? 1 : 0;

    logic       clk;
    logic       rst_n;
    logic [7:0] a_byte, b_byte;
    logic       a_valid, b_valid;
    logic       a_ready, a_tx, a_busy, a_done;
    logic       b_ready, b_tx, b_busy, b_done;

    uart_byte_tx #(.CLKS_PER_BIT(CLKS), .STOP_BITS(1)) u_a (
        .iCE_CLK(clk), .iCE_RST_N(rst_n), .tx_byte(a_byte), .tx_valid(a_valid),
        .tx_ready(a_ready), .TX(a_tx), .tx_busy(a_busy), .tx_done(a_done)
    );

    uart_byte_tx #(.CLKS_PER_BIT(CLKS), .STOP_BITS(2)) u_b (
        .iCE_CLK(clk), .iCE_RST_N(rst_n), .tx_byte(b_byte), .tx_valid(b_valid),
        .tx_ready(b_ready), .TX(b_tx), .tx_busy(b_busy), .tx_done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;  // wire order, MSB first: start, d0..d7, stop
        logic       par;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic tx_of(input int u);    return (u == 0) ? a_tx    : b_tx;    endfunction
    function automatic logic ready_of(input int u); return (u == 0) ? a_ready : b_ready; endfunction
    function automatic logic busy_of(input int u);  return (u == 0) ? a_busy  : b_busy;  endfunction
    function automatic logic done_of(input int u);  return (u == 0) ? a_done  : b_done;  endfunction

    task automatic drive(input int u, input logic v, input logic [7:0] d);
        if (u == 0) begin a_valid = v; a_byte = d; end
        else        begin b_valid = v; b_byte = d; end
    endtask

    task automatic push_bits(input logic v, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(v);
    endtask

    // Reference frame from the byte value: start, LSB-first data, even parity, stop bits.
    task automatic build_frame(input logic [7:0] b, input int stop_bits);
        int val;
        val = int'(b);
        push_bits(1'b0, CLKS);
        for (int i = 0; i < 8; i++) push_bits(logic'((val / (1 << i)) % 2), CLKS);
        if (PAR_EN) push_bits(logic'($countones(b) % 2), CLKS);
        push_bits(1'b1, stop_bits * CLKS);
    endtask

    task automatic from_line(input logic [9:0] line, input logic par);
        for (int k = 9; k >= 0; k--) begin
            if (k == 0 && PAR_EN) push_bits(par, CLKS);
            push_bits(line[k], CLKS);
        end
    endtask

    task automatic wait_ready(input int u, input string name);
        int k;
        k = 0;
        while (!ready_of(u) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!ready_of(u)) check({name, "_ready_timeout"}, 32'(ready_of(u)), 32'd1);
    endtask

    // Sends one byte and compares every cycle from the first post-acceptance cycle.
    task automatic run_frame(input int u, input logic [7:0] b, input string name,
                             input int chg_at, input logic [7:0] chg_byte, output int done_at);
        int n, bad, first, busy_bad, dones;
        n = exp_q.size(); bad = 0; first = -1; busy_bad = 0; dones = 0; done_at = -1;
        wait_ready(u, name);
        drive(u, 1'b1, b);
        @(negedge clk);
        drive(u, 1'b0, b);
        for (int j = 0; j < n; j++) begin
            if (j == chg_at) drive(u, 1'b0, chg_byte);
            if (tx_of(u) !== exp_q[j]) begin
                bad++;
                if (first < 0) first = j;
            end
            if (busy_of(u) === ready_of(u)) busy_bad++;
            if (done_of(u)) begin
                dones++;
                done_at = j;
            end
            @(negedge clk);
        end
        check($sformatf("%s_wave_bad_cycles(first=%0d)", name, first), bad, 0);
        check({name, "_done_count"}, dones, 1);
        check({name, "_done_cycle"}, done_at, n - 1);
        check({name, "_busy_vs_ready"}, busy_bad, 0);
        check({name, "_idle_after"}, 32'({tx_of(u), ready_of(u)}), 32'd3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   d, len, bad, rdy_cnt, rdy_at, dones, lows;
        vecs[0] = '{8'hA5, 10'b0101001011, 1'b0};
        vecs[1] = '{8'h0F, 10'b0111100001, 1'b0};
        vecs[2] = '{8'h3C, 10'b0001111001, 1'b0};
        vecs[3] = '{8'h07, 10'b0111000001, 1'b1};
        vecs[4] = '{8'h03, 10'b0110000001, 1'b0};
        vecs[5] = '{8'h80, 10'b0000000011, 1'b1};

        rst_n = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        check("reset_a_tx_ready_busy_done", 32'({a_tx, a_ready, a_busy, a_done}), 32'hA);
        check("reset_b_tx_ready_busy_done", 32'({b_tx, b_ready, b_busy, b_done}), 32'hA);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_a_ready", 32'(a_ready), 32'd1);
        check("release_b_ready", 32'(b_ready), 32'd1);

        // Table of hand-derived frames on unit A.
        for (int i = 0; i < 6; i++) begin
            exp_q.delete();
            from_line(vecs[i].line, vecs[i].par);
            run_frame(0, vecs[i].data, $sformatf("vec_%02h", vecs[i].data), -1, 8'h00, d);
            check($sformatf("vec_%02h_frame_len", vecs[i].data), d + 1, (10 + PAR) * CLKS);
        end

        // Byte input changes after acceptance must not reach the line.
        exp_q.delete();
        build_frame(8'h3C, 1);
        run_frame(0, 8'h3C, "hold_3c", 1, 8'hC3, d);

        // Back-to-back: valid held high, 0x00 then 0xFF, one idle-high cycle between frames.
        exp_q.delete();
        build_frame(8'h00, 1);
        len = exp_q.size();
        exp_q.push_back(1'b1);
        build_frame(8'hFF, 1);
        wait_ready(0, "b2b");
        drive(0, 1'b1, 8'h00);
        @(negedge clk);
        drive(0, 1'b1, 8'hFF);
        bad = 0; rdy_cnt = 0; rdy_at = -1; dones = 0;
        for (int j = 0; j < exp_q.size(); j++) begin
            if (j == len + 1) drive(0, 1'b0, 8'hFF);
            if (a_tx !== exp_q[j]) bad++;
            if (a_ready) begin
                rdy_cnt++;
                rdy_at = j;
            end
            if (a_done) dones++;
            @(negedge clk);
        end
        check("b2b_wave_bad_cycles", bad, 0);
        check("b2b_ready_cycles", rdy_cnt, 1);
        check("b2b_ready_cycle_index", rdy_at, len);
        check("b2b_done_count", dones, 2);

        // Reset asserted during data bit 3 of 0x0F.
        wait_ready(0, "rst_mid");
        drive(0, 1'b1, 8'h0F);
        @(negedge clk);
        drive(0, 1'b0, 8'h0F);
        repeat (17) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_async_tx_ready_busy_done", 32'({a_tx, a_ready, a_busy, a_done}), 32'hA);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_release_ready", 32'(a_ready), 32'd1);
        lows = 0; dones = 0; rdy_cnt = 0;
        for (int j = 0; j < 60; j++) begin
            if (a_tx !== 1'b1) lows++;
            if (a_done) dones++;
            if (a_ready !== 1'b1) rdy_cnt++;
            @(negedge clk);
        end
        check("rst_mid_residual_low_cycles", lows, 0);
        check("rst_mid_residual_done", dones, 0);
        check("rst_mid_ready_drops", rdy_cnt, 0);

        // Two stop bits on unit B.
        exp_q.delete();
        build_frame(8'h55, 2);
        run_frame(1, 8'h55, "stop2_55", -1, 8'h00, d);
        check("stop2_55_frame_len", d + 1, 44 + PAR * CLKS);

        // Random bytes on both units against the reference frame builder.
        for (int i = 0; i < 24; i++) begin
            int         u;
            logic [7:0] b;
            u = int'($urandom_range(0, 1));
            b = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            exp_q.delete();
            build_frame(b, (u == 0) ? 1 : 2);
            run_frame(u, b, $sformatf("rand%0d_u%0d_%02h", i, u, b), -1, 8'h00, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_byte_tx.md
UART_BYTE_TX -- requirements
Module: uart_byte_tx

Interface
REQ-001 The parameter CLKS_PER_BIT SHALL default to 104 and set the iCE_CLK cycles per UART bit (115200 baud at 12 MHz); the legal range SHALL be 2..65535.
REQ-002 The parameter STOP_BITS SHALL default to 1 and set the number of stop bits (legal values 1 or 2).
REQ-003 Port iCE_CLK SHALL be an input, 1 bit: the single system clock; all logic is rising-edge.
REQ-004 Port iCE_RST_N SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 Port tx_byte SHALL be an input, 8 bits: the byte to send, sampled only on acceptance.
REQ-006 Port tx_valid SHALL be an input, 1 bit: tx_byte is offered.
REQ-007 Port tx_ready SHALL be an output, 1 bit: the block can accept a byte this cycle.
REQ-008 Port TX SHALL be an output, 1 bit: the serial line, idle high.
REQ-009 Port tx_busy SHALL be an output, 1 bit: a frame is in progress.
REQ-010 Port tx_done SHALL be an output, 1 bit: a one-cycle pulse in the last cycle of the final stop bit.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; PARITY is present only when UART_TX_PARITY_EN is defined (see REQ-026).
REQ-012 tx_ready SHALL be high only in IDLE, combinationally from state, with no dependency on tx_valid.
REQ-013 Acceptance SHALL occur on a cycle with tx_valid and tx_ready both high: tx_byte is latched into a shift register and the FSM moves to START.
REQ-014 TX SHALL go low on the first cycle after acceptance; acceptance-to-start-edge latency is 1 cycle.
REQ-015 Each bit (start, data, parity, stop) SHALL be held for exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded at each bit boundary.
REQ-016 Data SHALL be sent LSB first, 8 bits, with a 3-bit index running 0..7; DATA exits after index 7 completes.
REQ-017 STOP SHALL drive TX high for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
REQ-018 tx_done SHALL pulse in the last STOP cycle, and tx_ready SHALL be high on the next cycle.
REQ-019 Back-to-back frames: if tx_valid is high on the first IDLE cycle, the next start bit SHALL begin one cycle later, giving exactly 1 idle-high cycle between frames.
REQ-020 Changes to tx_byte or tx_valid after acceptance SHALL have no effect on the frame in progress.
REQ-021 tx_busy SHALL equal NOT tx_ready.
REQ-022 TX SHALL be driven from a register (glitch-free).
REQ-023 Frame length without parity SHALL be (9+STOP_BITS)*CLKS_PER_BIT cycles.

Reset
REQ-024 While iCE_RST_N is low, outputs SHALL be: TX=1, tx_ready=0, tx_busy=1, tx_done=0; the state SHALL be IDLE and the counters and shift register SHALL be 0.
REQ-025 Assertion mid-frame SHALL force TX=1 immediately (asynchronously) and abort the frame; after deassertion, tx_ready SHALL rise on the first clock edge, and no partial frame SHALL resume.

Configuration
REQ-026 With macro UART_TX_PARITY_EN defined, an even-parity bit (XOR of the 8 data bits) SHALL be sent between DATA and STOP for CLKS_PER_BIT cycles, making the frame (10+STOP_BITS)*CLKS_PER_BIT cycles long.
REQ-027 Without UART_TX_PARITY_EN, the PARITY state and parity logic SHALL be absent, and DATA SHALL go directly to STOP.

Verification
REQ-028 The bench SHALL cover a single byte: CLKS_PER_BIT=4, send 0xA5 -> TX sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; start edge 1 cycle after acceptance; tx_done pulses once.
REQ-029 The bench SHALL cover back-to-back transfers: tx_valid held high with 0x00 then 0xFF -> two frames separated by exactly 1 high cycle; tx_ready high for exactly 1 cycle between them.
REQ-030 The bench SHALL cover reset mid-frame: assert iCE_RST_N low during data bit 3 of 0x0F -> TX=1 in the same cycle; after release, tx_ready=1 and TX stays high with no residual bits.
REQ-031 The bench SHALL cover input hold: change tx_byte from 0x3C to 0xC3 two cycles after acceptance -> the line carries 0x3C.
REQ-032 The bench SHALL cover parity: with UART_TX_PARITY_EN and 0x07 sent -> parity bit 1 and frame length 11*CLKS_PER_BIT; with 0x03 sent -> parity bit 0.
REQ-033 The bench SHALL cover two stop bits: STOP_BITS=2, CLKS_PER_BIT=4, send 0x55 -> TX high for 8 cycles before tx_done, and total frame length 44 cycles.
